// File: rtl/axi4_id_compactor.sv
// AXI4 ID compactor: maps a wide master ID space onto 2^OUT_ID_BITS slave IDs per direction,
// tracking outstanding transactions per slot and restoring the original ID on responses.

module axi4_id_compactor_table #(
   parameter int IN_ID_BITS      = 8,
   parameter int OUT_ID_BITS     = 2,
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [IN_ID_BITS-1:0]  i_req_id,
   input  logic                   i_acq,
   input  logic                   i_rel,
   input  logic [OUT_ID_BITS-1:0] i_rel_slot,
   output logic                   o_can_map,
   output logic [OUT_ID_BITS-1:0] o_slot,
   output logic [IN_ID_BITS-1:0]  o_rel_tag,
   output logic                   o_rel_err
);
   localparam int SLOTS = 1 << OUT_ID_BITS;
   localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [SLOTS-1:0]      r_valid;
   logic [IN_ID_BITS-1:0] r_tag [SLOTS];
   logic [CNT_W-1:0]      r_cnt [SLOTS];

   logic                   w_hit;
   logic                   w_free;
   logic [OUT_ID_BITS-1:0] w_hit_idx;
   logic [OUT_ID_BITS-1:0] w_free_idx;
   logic [SLOTS-1:0]       w_acq_vec;
   logic [SLOTS-1:0]       w_rel_vec;

   // Descending scan so the lowest-index match/free slot wins.
   always_comb begin
      w_hit      = 1'b0;
      w_free     = 1'b0;
      w_hit_idx  = '0;
      w_free_idx = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (r_valid[i] && (r_tag[i] == i_req_id)) begin
            w_hit     = 1'b1;
            w_hit_idx = OUT_ID_BITS'(i);
         end
         if (!r_valid[i]) begin
            w_free     = 1'b1;
            w_free_idx = OUT_ID_BITS'(i);
         end
      end
   end

   // A hit on a full slot stalls even if another slot is free, keeping one ID on one slave ID.
   assign o_can_map = w_hit ? (r_cnt[w_hit_idx] < C_MAX) : w_free;
   assign o_slot    = w_hit ? w_hit_idx : w_free_idx;
   assign o_rel_tag = r_tag[i_rel_slot];
   assign o_rel_err = i_rel && (r_cnt[i_rel_slot] == '0);

   always_comb begin
      w_acq_vec = '0;
      w_rel_vec = '0;
      for (int i = 0; i < SLOTS; i++) begin
         w_acq_vec[i] = i_acq && (o_slot == OUT_ID_BITS'(i));
         w_rel_vec[i] = i_rel && (i_rel_slot == OUT_ID_BITS'(i)) && (r_cnt[i] != '0);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_valid <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            r_tag[i] <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            if (w_acq_vec[i]) begin
               r_valid[i] <= 1'b1;
               r_tag[i]   <= i_req_id;
               if (!w_rel_vec[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (w_rel_vec[i]) begin
               r_cnt[i] <= r_cnt[i] - CNT_W'(1);
               if (r_cnt[i] == CNT_W'(1)) r_valid[i] <= 1'b0;
            end
         end
      end
   end
endmodule

module axi4_id_compactor #(
   parameter int IN_ID_BITS      = 8,
   parameter int OUT_ID_BITS     = 2,
   parameter int MAX_OUTSTANDING = 8,
   parameter int ADDR_BITS       = 31,
   parameter int DATA_BITS       = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   // master-side AW
   output logic                   auto_in_aw_ready,
   input  logic                   auto_in_aw_valid,
   input  logic [IN_ID_BITS-1:0]  auto_in_aw_bits_id,
   input  logic [ADDR_BITS-1:0]   auto_in_aw_bits_addr,
   input  logic [7:0]             auto_in_aw_bits_len,
   input  logic [2:0]             auto_in_aw_bits_size,
   input  logic [1:0]             auto_in_aw_bits_burst,
   input  logic                   auto_in_aw_bits_lock,
   input  logic [3:0]             auto_in_aw_bits_cache,
   input  logic [2:0]             auto_in_aw_bits_prot,
   input  logic [3:0]             auto_in_aw_bits_qos,
   input  logic [3:0]             auto_in_aw_bits_echo_tl_state_size,
   input  logic [4:0]             auto_in_aw_bits_echo_tl_state_source,
   // master-side W
   output logic                   auto_in_w_ready,
   input  logic                   auto_in_w_valid,
   input  logic [DATA_BITS-1:0]   auto_in_w_bits_data,
   input  logic [DATA_BITS/8-1:0] auto_in_w_bits_strb,
   input  logic                   auto_in_w_bits_last,
   // master-side B
   input  logic                   auto_in_b_ready,
   output logic                   auto_in_b_valid,
   output logic [IN_ID_BITS-1:0]  auto_in_b_bits_id,
   output logic [1:0]             auto_in_b_bits_resp,
   output logic [3:0]             auto_in_b_bits_echo_tl_state_size,
   output logic [4:0]             auto_in_b_bits_echo_tl_state_source,
   // master-side AR
   output logic                   auto_in_ar_ready,
   input  logic                   auto_in_ar_valid,
   input  logic [IN_ID_BITS-1:0]  auto_in_ar_bits_id,
   input  logic [ADDR_BITS-1:0]   auto_in_ar_bits_addr,
   input  logic [7:0]             auto_in_ar_bits_len,
   input  logic [2:0]             auto_in_ar_bits_size,
   input  logic [1:0]             auto_in_ar_bits_burst,
   input  logic                   auto_in_ar_bits_lock,
   input  logic [3:0]             auto_in_ar_bits_cache,
   input  logic [2:0]             auto_in_ar_bits_prot,
   input  logic [3:0]             auto_in_ar_bits_qos,
   input  logic [3:0]             auto_in_ar_bits_echo_tl_state_size,
   input  logic [4:0]             auto_in_ar_bits_echo_tl_state_source,
   // master-side R
   input  logic                   auto_in_r_ready,
   output logic                   auto_in_r_valid,
   output logic [IN_ID_BITS-1:0]  auto_in_r_bits_id,
   output logic [DATA_BITS-1:0]   auto_in_r_bits_data,
   output logic [1:0]             auto_in_r_bits_resp,
   output logic [3:0]             auto_in_r_bits_echo_tl_state_size,
   output logic [4:0]             auto_in_r_bits_echo_tl_state_source,
   output logic                   auto_in_r_bits_last,
   // slave-side AW
   input  logic                   auto_out_aw_ready,
   output logic                   auto_out_aw_valid,
   output logic [OUT_ID_BITS-1:0] auto_out_aw_bits_id,
   output logic [ADDR_BITS-1:0]   auto_out_aw_bits_addr,
   output logic [7:0]             auto_out_aw_bits_len,
   output logic [2:0]             auto_out_aw_bits_size,
   output logic [1:0]             auto_out_aw_bits_burst,
   output logic                   auto_out_aw_bits_lock,
   output logic [3:0]             auto_out_aw_bits_cache,
   output logic [2:0]             auto_out_aw_bits_prot,
   output logic [3:0]             auto_out_aw_bits_qos,
   output logic [3:0]             auto_out_aw_bits_echo_tl_state_size,
   output logic [4:0]             auto_out_aw_bits_echo_tl_state_source,
   // slave-side W
   input  logic                   auto_out_w_ready,
   output logic                   auto_out_w_valid,
   output logic [DATA_BITS-1:0]   auto_out_w_bits_data,
   output logic [DATA_BITS/8-1:0] auto_out_w_bits_strb,
   output logic                   auto_out_w_bits_last,
   // slave-side B
   output logic                   auto_out_b_ready,
   input  logic                   auto_out_b_valid,
   input  logic [OUT_ID_BITS-1:0] auto_out_b_bits_id,
   input  logic [1:0]             auto_out_b_bits_resp,
   input  logic [3:0]             auto_out_b_bits_echo_tl_state_size,
   input  logic [4:0]             auto_out_b_bits_echo_tl_state_source,
   // slave-side AR
   input  logic                   auto_out_ar_ready,
   output logic                   auto_out_ar_valid,
   output logic [OUT_ID_BITS-1:0] auto_out_ar_bits_id,
   output logic [ADDR_BITS-1:0]   auto_out_ar_bits_addr,
   output logic [7:0]             auto_out_ar_bits_len,
   output logic [2:0]             auto_out_ar_bits_size,
   output logic [1:0]             auto_out_ar_bits_burst,
   output logic                   auto_out_ar_bits_lock,
   output logic [3:0]             auto_out_ar_bits_cache,
   output logic [2:0]             auto_out_ar_bits_prot,
   output logic [3:0]             auto_out_ar_bits_qos,
   output logic [3:0]             auto_out_ar_bits_echo_tl_state_size,
   output logic [4:0]             auto_out_ar_bits_echo_tl_state_source,
   // slave-side R
   output logic                   auto_out_r_ready,
   input  logic                   auto_out_r_valid,
   input  logic [OUT_ID_BITS-1:0] auto_out_r_bits_id,
   input  logic [DATA_BITS-1:0]   auto_out_r_bits_data,
   input  logic [1:0]             auto_out_r_bits_resp,
   input  logic [3:0]             auto_out_r_bits_echo_tl_state_size,
   input  logic [4:0]             auto_out_r_bits_echo_tl_state_source,
   input  logic                   auto_out_r_bits_last,
   output logic                   io_error
);
   logic                   w_aw_can, w_ar_can;
   logic [OUT_ID_BITS-1:0] w_aw_slot, w_ar_slot;
   logic                   w_aw_acq, w_ar_acq, w_b_rel, w_r_rel;
   logic                   w_b_err, w_r_err;
   logic                   r_error;

   assign w_aw_acq = auto_in_aw_valid && auto_out_aw_ready && w_aw_can;
   assign w_ar_acq = auto_in_ar_valid && auto_out_ar_ready && w_ar_can;
   assign w_b_rel  = auto_out_b_valid && auto_in_b_ready;
   // Only the final R beat retires a read burst.
   assign w_r_rel  = auto_out_r_valid && auto_in_r_ready && auto_out_r_bits_last;

   axi4_id_compactor_table #(
      .IN_ID_BITS(IN_ID_BITS), .OUT_ID_BITS(OUT_ID_BITS), .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_wr_table (
      .clock(clock), .reset(reset), .i_req_id(auto_in_aw_bits_id), .i_acq(w_aw_acq),
      .i_rel(w_b_rel), .i_rel_slot(auto_out_b_bits_id), .o_can_map(w_aw_can),
      .o_slot(w_aw_slot), .o_rel_tag(auto_in_b_bits_id), .o_rel_err(w_b_err)
   );

   axi4_id_compactor_table #(
      .IN_ID_BITS(IN_ID_BITS), .OUT_ID_BITS(OUT_ID_BITS), .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_rd_table (
      .clock(clock), .reset(reset), .i_req_id(auto_in_ar_bits_id), .i_acq(w_ar_acq),
      .i_rel(w_r_rel), .i_rel_slot(auto_out_r_bits_id), .o_can_map(w_ar_can),
      .o_slot(w_ar_slot), .o_rel_tag(auto_in_r_bits_id), .o_rel_err(w_r_err)
   );

   assign auto_out_aw_valid                     = auto_in_aw_valid && w_aw_can;
   assign auto_in_aw_ready                      = auto_out_aw_ready && w_aw_can;
   assign auto_out_aw_bits_id                   = w_aw_slot;
   assign auto_out_aw_bits_addr                 = auto_in_aw_bits_addr;
   assign auto_out_aw_bits_len                  = auto_in_aw_bits_len;
   assign auto_out_aw_bits_size                 = auto_in_aw_bits_size;
   assign auto_out_aw_bits_burst                = auto_in_aw_bits_burst;
   assign auto_out_aw_bits_lock                 = auto_in_aw_bits_lock;
   assign auto_out_aw_bits_cache                = auto_in_aw_bits_cache;
   assign auto_out_aw_bits_prot                 = auto_in_aw_bits_prot;
   assign auto_out_aw_bits_qos                  = auto_in_aw_bits_qos;
   assign auto_out_aw_bits_echo_tl_state_size   = auto_in_aw_bits_echo_tl_state_size;
   assign auto_out_aw_bits_echo_tl_state_source = auto_in_aw_bits_echo_tl_state_source;

   assign auto_out_ar_valid                     = auto_in_ar_valid && w_ar_can;
   assign auto_in_ar_ready                      = auto_out_ar_ready && w_ar_can;
   assign auto_out_ar_bits_id                   = w_ar_slot;
   assign auto_out_ar_bits_addr                 = auto_in_ar_bits_addr;
   assign auto_out_ar_bits_len                  = auto_in_ar_bits_len;
   assign auto_out_ar_bits_size                 = auto_in_ar_bits_size;
   assign auto_out_ar_bits_burst                = auto_in_ar_bits_burst;
   assign auto_out_ar_bits_lock                 = auto_in_ar_bits_lock;
   assign auto_out_ar_bits_cache                = auto_in_ar_bits_cache;
   assign auto_out_ar_bits_prot                 = auto_in_ar_bits_prot;
   assign auto_out_ar_bits_qos                  = auto_in_ar_bits_qos;
   assign auto_out_ar_bits_echo_tl_state_size   = auto_in_ar_bits_echo_tl_state_size;
   assign auto_out_ar_bits_echo_tl_state_source = auto_in_ar_bits_echo_tl_state_source;

   assign auto_out_w_valid     = auto_in_w_valid;
   assign auto_in_w_ready      = auto_out_w_ready;
   assign auto_out_w_bits_data = auto_in_w_bits_data;
   assign auto_out_w_bits_strb = auto_in_w_bits_strb;
   assign auto_out_w_bits_last = auto_in_w_bits_last;

   assign auto_in_b_valid                     = auto_out_b_valid;
   assign auto_out_b_ready                    = auto_in_b_ready;
   assign auto_in_b_bits_resp                 = auto_out_b_bits_resp;
   assign auto_in_b_bits_echo_tl_state_size   = auto_out_b_bits_echo_tl_state_size;
   assign auto_in_b_bits_echo_tl_state_source = auto_out_b_bits_echo_tl_state_source;

   assign auto_in_r_valid                     = auto_out_r_valid;
   assign auto_out_r_ready                    = auto_in_r_ready;
   assign auto_in_r_bits_data                 = auto_out_r_bits_data;
   assign auto_in_r_bits_resp                 = auto_out_r_bits_resp;
   assign auto_in_r_bits_echo_tl_state_size   = auto_out_r_bits_echo_tl_state_size;
   assign auto_in_r_bits_echo_tl_state_source = auto_out_r_bits_echo_tl_state_source;
   assign auto_in_r_bits_last                 = auto_out_r_bits_last;

   // Sticky: a response for a slot with nothing outstanding.
   always_ff @(posedge clock) begin
      if (!reset) r_error <= 1'b0;
      else        r_error <= r_error || w_b_err || w_r_err;
   end

   assign io_error = r_error;
endmodule

// File: tb/tb_axi4_id_compactor.sv
// Scoreboard bench for axi4_id_compactor: stimulus pushes expected IDs and level checks,
// a negedge monitor pops and compares them against what the DUT presents.

module tb_axi4_id_compactor;
   localparam int IB = 8, OB = 2, AB = 31, DB = 64;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic          auto_in_aw_ready, auto_in_aw_valid;
   logic [IB-1:0] auto_in_aw_bits_id;
   logic [AB-1:0] auto_in_aw_bits_addr;
   logic [7:0]    auto_in_aw_bits_len;
   logic          auto_in_w_ready, auto_in_w_valid, auto_in_w_bits_last;
   logic [DB-1:0] auto_in_w_bits_data;
   logic [DB/8-1:0] auto_in_w_bits_strb;
   logic          auto_in_b_ready, auto_in_b_valid;
   logic [IB-1:0] auto_in_b_bits_id;
   logic [1:0]    auto_in_b_bits_resp;
   logic [3:0]    auto_in_b_bits_echo_tl_state_size;
   logic [4:0]    auto_in_b_bits_echo_tl_state_source;
   logic          auto_in_ar_ready, auto_in_ar_valid;
   logic [IB-1:0] auto_in_ar_bits_id;
   logic [AB-1:0] auto_in_ar_bits_addr;
   logic [7:0]    auto_in_ar_bits_len;
   logic          auto_in_r_ready, auto_in_r_valid, auto_in_r_bits_last;
   logic [IB-1:0] auto_in_r_bits_id;
   logic [DB-1:0] auto_in_r_bits_data;
   logic [1:0]    auto_in_r_bits_resp;
   logic [3:0]    auto_in_r_bits_echo_tl_state_size;
   logic [4:0]    auto_in_r_bits_echo_tl_state_source;
   logic          auto_out_aw_ready, auto_out_aw_valid;
   logic [OB-1:0] auto_out_aw_bits_id;
   logic [AB-1:0] auto_out_aw_bits_addr;
   logic [7:0]    auto_out_aw_bits_len;
   logic [2:0]    auto_out_aw_bits_size, auto_out_aw_bits_prot;
   logic [1:0]    auto_out_aw_bits_burst;
   logic          auto_out_aw_bits_lock;
   logic [3:0]    auto_out_aw_bits_cache, auto_out_aw_bits_qos, auto_out_aw_bits_echo_tl_state_size;
   logic [4:0]    auto_out_aw_bits_echo_tl_state_source;
   logic          auto_out_w_ready, auto_out_w_valid, auto_out_w_bits_last;
   logic [DB-1:0] auto_out_w_bits_data;
   logic [DB/8-1:0] auto_out_w_bits_strb;
   logic          auto_out_b_ready, auto_out_b_valid;
   logic [OB-1:0] auto_out_b_bits_id;
   logic          auto_out_ar_ready, auto_out_ar_valid;
   logic [OB-1:0] auto_out_ar_bits_id;
   logic [AB-1:0] auto_out_ar_bits_addr;
   logic [7:0]    auto_out_ar_bits_len;
   logic [2:0]    auto_out_ar_bits_size, auto_out_ar_bits_prot;
   logic [1:0]    auto_out_ar_bits_burst;
   logic          auto_out_ar_bits_lock;
   logic [3:0]    auto_out_ar_bits_cache, auto_out_ar_bits_qos, auto_out_ar_bits_echo_tl_state_size;
   logic [4:0]    auto_out_ar_bits_echo_tl_state_source;
   logic          auto_out_r_ready, auto_out_r_valid, auto_out_r_bits_last;
   logic [OB-1:0] auto_out_r_bits_id;
   logic [DB-1:0] auto_out_r_bits_data;
   logic          io_error;

   axi4_id_compactor dut (
      .clock(clock), .reset(reset),
      .auto_in_aw_ready(auto_in_aw_ready), .auto_in_aw_valid(auto_in_aw_valid),
      .auto_in_aw_bits_id(auto_in_aw_bits_id), .auto_in_aw_bits_addr(auto_in_aw_bits_addr),
      .auto_in_aw_bits_len(auto_in_aw_bits_len), .auto_in_aw_bits_size(3'd3),
      .auto_in_aw_bits_burst(2'd1), .auto_in_aw_bits_lock(1'b0), .auto_in_aw_bits_cache(4'h0),
      .auto_in_aw_bits_prot(3'd0), .auto_in_aw_bits_qos(4'h0),
      .auto_in_aw_bits_echo_tl_state_size(4'h3), .auto_in_aw_bits_echo_tl_state_source(5'h01),
      .auto_in_w_ready(auto_in_w_ready), .auto_in_w_valid(auto_in_w_valid),
      .auto_in_w_bits_data(auto_in_w_bits_data), .auto_in_w_bits_strb(auto_in_w_bits_strb),
      .auto_in_w_bits_last(auto_in_w_bits_last),
      .auto_in_b_ready(auto_in_b_ready), .auto_in_b_valid(auto_in_b_valid),
      .auto_in_b_bits_id(auto_in_b_bits_id), .auto_in_b_bits_resp(auto_in_b_bits_resp),
      .auto_in_b_bits_echo_tl_state_size(auto_in_b_bits_echo_tl_state_size),
      .auto_in_b_bits_echo_tl_state_source(auto_in_b_bits_echo_tl_state_source),
      .auto_in_ar_ready(auto_in_ar_ready), .auto_in_ar_valid(auto_in_ar_valid),
      .auto_in_ar_bits_id(auto_in_ar_bits_id), .auto_in_ar_bits_addr(auto_in_ar_bits_addr),
      .auto_in_ar_bits_len(auto_in_ar_bits_len), .auto_in_ar_bits_size(3'd3),
      .auto_in_ar_bits_burst(2'd1), .auto_in_ar_bits_lock(1'b0), .auto_in_ar_bits_cache(4'h0),
      .auto_in_ar_bits_prot(3'd0), .auto_in_ar_bits_qos(4'h0),
      .auto_in_ar_bits_echo_tl_state_size(4'h3), .auto_in_ar_bits_echo_tl_state_source(5'h02),
      .auto_in_r_ready(auto_in_r_ready), .auto_in_r_valid(auto_in_r_valid),
      .auto_in_r_bits_id(auto_in_r_bits_id), .auto_in_r_bits_data(auto_in_r_bits_data),
      .auto_in_r_bits_resp(auto_in_r_bits_resp),
      .auto_in_r_bits_echo_tl_state_size(auto_in_r_bits_echo_tl_state_size),
      .auto_in_r_bits_echo_tl_state_source(auto_in_r_bits_echo_tl_state_source),
      .auto_in_r_bits_last(auto_in_r_bits_last),
      .auto_out_aw_ready(auto_out_aw_ready), .auto_out_aw_valid(auto_out_aw_valid),
      .auto_out_aw_bits_id(auto_out_aw_bits_id), .auto_out_aw_bits_addr(auto_out_aw_bits_addr),
      .auto_out_aw_bits_len(auto_out_aw_bits_len), .auto_out_aw_bits_size(auto_out_aw_bits_size),
      .auto_out_aw_bits_burst(auto_out_aw_bits_burst), .auto_out_aw_bits_lock(auto_out_aw_bits_lock),
      .auto_out_aw_bits_cache(auto_out_aw_bits_cache), .auto_out_aw_bits_prot(auto_out_aw_bits_prot),
      .auto_out_aw_bits_qos(auto_out_aw_bits_qos),
      .auto_out_aw_bits_echo_tl_state_size(auto_out_aw_bits_echo_tl_state_size),
      .auto_out_aw_bits_echo_tl_state_source(auto_out_aw_bits_echo_tl_state_source),
      .auto_out_w_ready(auto_out_w_ready), .auto_out_w_valid(auto_out_w_valid),
      .auto_out_w_bits_data(auto_out_w_bits_data), .auto_out_w_bits_strb(auto_out_w_bits_strb),
      .auto_out_w_bits_last(auto_out_w_bits_last),
      .auto_out_b_ready(auto_out_b_ready), .auto_out_b_valid(auto_out_b_valid),
      .auto_out_b_bits_id(auto_out_b_bits_id), .auto_out_b_bits_resp(2'd0),
      .auto_out_b_bits_echo_tl_state_size(4'h3), .auto_out_b_bits_echo_tl_state_source(5'h01),
      .auto_out_ar_ready(auto_out_ar_ready), .auto_out_ar_valid(auto_out_ar_valid),
      .auto_out_ar_bits_id(auto_out_ar_bits_id), .auto_out_ar_bits_addr(auto_out_ar_bits_addr),
      .auto_out_ar_bits_len(auto_out_ar_bits_len), .auto_out_ar_bits_size(auto_out_ar_bits_size),
      .auto_out_ar_bits_burst(auto_out_ar_bits_burst), .auto_out_ar_bits_lock(auto_out_ar_bits_lock),
      .auto_out_ar_bits_cache(auto_out_ar_bits_cache), .auto_out_ar_bits_prot(auto_out_ar_bits_prot),
      .auto_out_ar_bits_qos(auto_out_ar_bits_qos),
      .auto_out_ar_bits_echo_tl_state_size(auto_out_ar_bits_echo_tl_state_size),
      .auto_out_ar_bits_echo_tl_state_source(auto_out_ar_bits_echo_tl_state_source),
      .auto_out_r_ready(auto_out_r_ready), .auto_out_r_valid(auto_out_r_valid),
      .auto_out_r_bits_id(auto_out_r_bits_id), .auto_out_r_bits_data(auto_out_r_bits_data),
      .auto_out_r_bits_resp(2'd0), .auto_out_r_bits_echo_tl_state_size(4'h3),
      .auto_out_r_bits_echo_tl_state_source(5'h02), .auto_out_r_bits_last(auto_out_r_bits_last),
      .io_error(io_error)
   );

   localparam int S_AW_READY = 0, S_AR_READY = 1, S_ERR = 2, S_AW_ADDR = 3, S_B_VALID = 4;
   typedef struct { int sig; logic [31:0] exp; } chk_t;

   logic [OB-1:0] q_aw[$], q_ar[$];
   logic [IB-1:0] q_b[$], q_r[$];
   chk_t          q_chk[$];
   chk_t          c;
   int            n_tests = 0, n_fail = 0;
   logic          done = 1'b0;
   logic [31:0]   act;

   function automatic string sig_name(input int s);
      case (s)
         S_AW_READY: return "aw_ready";
         S_AR_READY: return "ar_ready";
         S_ERR:      return "io_error";
         S_AW_ADDR:  return "aw_addr";
         default:    return "b_valid";
      endcase
   endfunction

   always @(negedge clock) begin
      if (auto_out_aw_valid && auto_out_aw_ready) begin
         n_tests++;
         if (q_aw.size() == 0) begin
            n_fail++; $display("FAIL aw_unexpected out_id=%0d", auto_out_aw_bits_id);
         end else if (auto_out_aw_bits_id !== q_aw[0]) begin
            n_fail++; $display("FAIL aw_out_id got=%0d exp=%0d", auto_out_aw_bits_id, q_aw[0]);
         end
         if (q_aw.size() != 0) void'(q_aw.pop_front());
      end
      if (auto_out_ar_valid && auto_out_ar_ready) begin
         n_tests++;
         if (q_ar.size() == 0) begin
            n_fail++; $display("FAIL ar_unexpected out_id=%0d", auto_out_ar_bits_id);
         end else if (auto_out_ar_bits_id !== q_ar[0]) begin
            n_fail++; $display("FAIL ar_out_id got=%0d exp=%0d", auto_out_ar_bits_id, q_ar[0]);
         end
         if (q_ar.size() != 0) void'(q_ar.pop_front());
      end
      if (auto_in_b_valid && auto_in_b_ready) begin
         n_tests++;
         if (q_b.size() == 0) begin
            n_fail++; $display("FAIL b_unexpected id=%h", auto_in_b_bits_id);
         end else if (auto_in_b_bits_id !== q_b[0]) begin
            n_fail++; $display("FAIL b_id got=%h exp=%h", auto_in_b_bits_id, q_b[0]);
         end
         if (q_b.size() != 0) void'(q_b.pop_front());
      end
      if (auto_in_r_valid && auto_in_r_ready) begin
         n_tests++;
         if (q_r.size() == 0) begin
            n_fail++; $display("FAIL r_unexpected id=%h", auto_in_r_bits_id);
         end else if (auto_in_r_bits_id !== q_r[0]) begin
            n_fail++; $display("FAIL r_id got=%h exp=%h", auto_in_r_bits_id, q_r[0]);
         end
         if (q_r.size() != 0) void'(q_r.pop_front());
      end
      while (q_chk.size() != 0) begin
         c = q_chk.pop_front();
         case (c.sig)
            S_AW_READY: act = 32'(auto_in_aw_ready);
            S_AR_READY: act = 32'(auto_in_ar_ready);
            S_ERR:      act = 32'(io_error);
            S_AW_ADDR:  act = 32'(auto_out_aw_bits_addr);
            default:    act = 32'(auto_in_b_valid);
         endcase
         n_tests++;
         if (act !== c.exp) begin
            n_fail++; $display("FAIL %s got=%h exp=%h", sig_name(c.sig), act, c.exp);
         end
      end
      if (done) begin
         n_tests++;
         if (q_aw.size() + q_ar.size() + q_b.size() + q_r.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending aw=%0d ar=%0d b=%0d r=%0d exp=0",
                     q_aw.size(), q_ar.size(), q_b.size(), q_r.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   task automatic push_chk(input int s, input logic [31:0] e);
      chk_t t;
      t.sig = s; t.exp = e;
      q_chk.push_back(t);
   endtask

   task automatic cyc();
      @(negedge clock); @(posedge clock); #1;
   endtask

   task automatic aw_drive(input logic [IB-1:0] id);
      auto_in_aw_valid = 1'b1; auto_in_aw_bits_id = id; auto_out_aw_ready = 1'b1;
      auto_in_aw_bits_addr = 31'h0123_4500 | 31'(id); auto_in_aw_bits_len = id;
   endtask

   task automatic aw_send(input logic [IB-1:0] id, input logic [OB-1:0] exp_out);
      aw_drive(id);
      q_aw.push_back(exp_out);
      push_chk(S_AW_READY, 32'd1);
      push_chk(S_AW_ADDR, 32'h0123_4500 | 32'(id));
      cyc();
      auto_in_aw_valid = 1'b0; auto_out_aw_ready = 1'b0;
   endtask

   task automatic aw_stall(input logic [IB-1:0] id);
      aw_drive(id);
      push_chk(S_AW_READY, 32'd0);
      cyc();
      auto_in_aw_valid = 1'b0; auto_out_aw_ready = 1'b0;
   endtask

   task automatic b_send(input logic [OB-1:0] slot, input logic [IB-1:0] exp_id);
      auto_out_b_valid = 1'b1; auto_out_b_bits_id = slot; auto_in_b_ready = 1'b1;
      q_b.push_back(exp_id);
      cyc();
      auto_out_b_valid = 1'b0; auto_in_b_ready = 1'b0;
   endtask

   task automatic ar_send(input logic [IB-1:0] id, input logic [OB-1:0] exp_out);
      auto_in_ar_valid = 1'b1; auto_in_ar_bits_id = id; auto_out_ar_ready = 1'b1;
      auto_in_ar_bits_addr = 31'h0200_0000; auto_in_ar_bits_len = 8'd3;
      q_ar.push_back(exp_out);
      push_chk(S_AR_READY, 32'd1);
      cyc();
      auto_in_ar_valid = 1'b0; auto_out_ar_ready = 1'b0;
   endtask

   task automatic r_send(input logic [OB-1:0] slot, input logic last, input logic [IB-1:0] exp_id);
      auto_out_r_valid = 1'b1; auto_out_r_bits_id = slot; auto_out_r_bits_last = last;
      auto_in_r_ready = 1'b1; auto_out_r_bits_data = 64'hDEAD_0000_0000_0000 | 64'(slot);
      q_r.push_back(exp_id);
      cyc();
      auto_out_r_valid = 1'b0; auto_in_r_ready = 1'b0; auto_out_r_bits_last = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      auto_in_aw_valid = 0; auto_in_aw_bits_id = 0; auto_in_aw_bits_addr = 0; auto_in_aw_bits_len = 0;
      auto_in_w_valid = 0; auto_in_w_bits_data = 0; auto_in_w_bits_strb = 0; auto_in_w_bits_last = 0;
      auto_in_b_ready = 0; auto_in_ar_valid = 0; auto_in_ar_bits_id = 0; auto_in_ar_bits_addr = 0;
      auto_in_ar_bits_len = 0; auto_in_r_ready = 0;
      auto_out_aw_ready = 0; auto_out_w_ready = 0; auto_out_b_valid = 0; auto_out_b_bits_id = 0;
      auto_out_ar_ready = 0; auto_out_r_valid = 0; auto_out_r_bits_id = 0; auto_out_r_bits_data = 0;
      auto_out_r_bits_last = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      push_chk(S_ERR, 32'd0); push_chk(S_B_VALID, 32'd0);
      cyc();

      // Single allocate/release, then the freed slot is reused.
      aw_send(8'h5A, 2'd0);
      b_send(2'd0, 8'h5A);
      aw_send(8'h99, 2'd0);
      b_send(2'd0, 8'h99);

      // Fill all four slots; a new ID stalls, and a slot freed this cycle is not yet usable.
      aw_send(8'h01, 2'd0); aw_send(8'h02, 2'd1); aw_send(8'h03, 2'd2); aw_send(8'h04, 2'd3);
      aw_stall(8'h77);
      aw_drive(8'h77);
      auto_out_b_valid = 1'b1; auto_out_b_bits_id = 2'd2; auto_in_b_ready = 1'b1;
      q_b.push_back(8'h03); push_chk(S_AW_READY, 32'd0);
      cyc();
      auto_out_b_valid = 1'b0; auto_in_b_ready = 1'b0; auto_in_aw_valid = 1'b0; auto_out_aw_ready = 1'b0;
      aw_send(8'h77, 2'd2);
      aw_send(8'h01, 2'd0);
      b_send(2'd0, 8'h01); b_send(2'd0, 8'h01); b_send(2'd1, 8'h02);
      b_send(2'd2, 8'h77); b_send(2'd3, 8'h04);

      // Outstanding limit on one slot; other IDs still map.
      for (int i = 0; i < 8; i++) aw_send(8'h10, 2'd0);
      aw_stall(8'h10);
      aw_send(8'h20, 2'd1);
      b_send(2'd0, 8'h10);
      aw_send(8'h10, 2'd0);
      b_send(2'd1, 8'h20);
      for (int i = 0; i < 8; i++) b_send(2'd0, 8'h10);
      push_chk(S_ERR, 32'd0);
      cyc();

      // Read burst: only the last beat releases the slot.
      ar_send(8'h33, 2'd0);
      r_send(2'd0, 1'b0, 8'h33); r_send(2'd0, 1'b0, 8'h33); r_send(2'd0, 1'b0, 8'h33);
      ar_send(8'h44, 2'd1);
      r_send(2'd0, 1'b1, 8'h33);
      ar_send(8'h55, 2'd0);
      r_send(2'd1, 1'b1, 8'h44); r_send(2'd0, 1'b1, 8'h55);

      // Acquire and release on the same slot in the same cycle.
      aw_send(8'h0A, 2'd0); aw_send(8'h0B, 2'd1);
      aw_drive(8'h0B);
      auto_out_b_valid = 1'b1; auto_out_b_bits_id = 2'd1; auto_in_b_ready = 1'b1;
      q_aw.push_back(2'd1); q_b.push_back(8'h0B); push_chk(S_AW_READY, 32'd1);
      cyc();
      auto_out_b_valid = 1'b0; auto_in_b_ready = 1'b0; auto_in_aw_valid = 1'b0; auto_out_aw_ready = 1'b0;
      b_send(2'd1, 8'h0B);
      push_chk(S_ERR, 32'd0);
      aw_send(8'h0C, 2'd1);
      b_send(2'd0, 8'h0A); b_send(2'd1, 8'h0C);
      push_chk(S_ERR, 32'd0);
      cyc();

      // Release on an empty slot: forwarded with the stale tag, error is sticky until reset.
      b_send(2'd3, 8'h04);
      push_chk(S_ERR, 32'd1); cyc();
      push_chk(S_ERR, 32'd1); cyc();
      reset = 1'b0; cyc();
      reset = 1'b1;
      push_chk(S_ERR, 32'd0); cyc();
      aw_send(8'hAB, 2'd0); aw_send(8'hCD, 2'd1);
      b_send(2'd3, 8'h00);
      push_chk(S_ERR, 32'd1); cyc();
      done = 1'b1;
   end
endmodule
